data_sram_like_responder: RTL and testbench
===========================================

// Module: data_sram_like_responder
// PURPOSE
//  Slave end of the data-side SRAM-like bus (req/wr/size/wstrb/addr/wdata -> addr_ok, data_ok/rdata).
//  Stands in for the data memory behind the pipeline's load/store issue logic.
//  Accepts requests into an in-order queue, commits writes to a local word array at acceptance,
//  and returns data_ok/rdata in order after a programmable latency.
//  Used in SoC-less simulation and for stressing addr_ok/data_ok stall paths.
// PARAMETERS
//  MEM_AW     10  word-address width of local array (2**MEM_AW x 32-bit words)
//  Q_DEPTH    2   outstanding request queue depth (power of 2, >=1)
//  ADDR_GAP   0   idle cycles forced after each acceptance before addr_ok may rise again
//  RESP_LAT   1   cycles from acceptance or previous data_ok to data_ok (>=1)
// PORTS
//  clk              in   1    clock, rising edge
//  resetn           in   1    asynchronous active-low reset
//  data_sram_req    in   1    request valid
//  data_sram_wr     in   1    1 = write, 0 = read
//  data_sram_size   in   2    0 = byte, 1 = half, 2 = word, 3 = treated as word
//  data_sram_wstrb  in   4    byte enables for writes
//  data_sram_addr   in   32   byte address; word index = addr[MEM_AW+1:2], upper bits alias
//  data_sram_wdata  in   32   write data, lane-aligned by master
//  data_sram_addr_ok out 1    request accepted this cycle when req is also high
//  data_sram_data_ok out 1    response valid, one cycle per accepted request
//  data_sram_rdata  out  32   full word read at acceptance; 0 for write responses
//  outstanding      out  $clog2(Q_DEPTH)+1  accepted requests not yet answered
// BEHAVIOUR
//  - Reset (resetn=0, async): queue empty, gap/latency counters 0, addr_ok=0, data_ok=0,
//    rdata=0, outstanding=0. Array contents not cleared. Reset mid-transaction drops all pending.
//  - addr_ok = resetn & ~q_full & (gap_cnt==0); combinational, no dependence on req.
//  - Acceptance = req & addr_ok at a rising edge. On acceptance:
//    write: array[idx] byte lanes with wstrb[i]=1 updated from wdata; wstrb=0 updates nothing.
//    read: array[idx] sampled into the queue entry (pre-write value irrelevant; one op per cycle).
//    queue push {wr, rdata}; gap_cnt <= ADDR_GAP.
//  - gap_cnt decrements each cycle while nonzero. ADDR_GAP=0 allows back-to-back acceptance.
//  - Full queue: addr_ok=0 even if data_ok pops the head in the same cycle; no bypass.
//  - Latency counter lat_cnt tracks head entry:
//    loaded with RESP_LAT-1 when an entry becomes head (push into empty queue, or pop with
//    another entry behind); decremented while nonzero.
//  - data_ok = q_nonempty & (lat_cnt==0), registered-state based, no comb path from req.
//    Accept in cycle T into empty queue -> data_ok in T+RESP_LAT. Next entry's data_ok is at
//    least RESP_LAT cycles after the previous one. Master always accepts data_ok (no backpressure).
//  - rdata = head rdata while data_ok, else 0. size is not used for masking; master extracts lanes.
//  - Simultaneous push and pop: both occur; outstanding unchanged; order preserved.
//  - outstanding = push count - pop count, range 0..Q_DEPTH.
//  - Read-after-write to the same word, each accepted in order, returns the written data.
// TESTING
//  1 Reset: hold resetn=0 with req=1 -> addr_ok=0, data_ok=0, rdata=0; release -> addr_ok=1 next cycle.
//  2 Write then read, RESP_LAT=1: wr addr 0x10 wdata 0xA5A5_1234 wstrb 4'hF, then rd 0x10 ->
//    data_ok in each following cycle, read rdata=0xA5A5_1234.
//  3 Byte write: wr addr 0x13 wstrb 4'h8 wdata 0x7700_0000 over 0xA5A5_1234 ->
//    read 0x10 returns 0x77A5_1234; wstrb 4'h0 write leaves word unchanged and still gets data_ok.
//  4 Queue full, Q_DEPTH=2, RESP_LAT=4: req held high -> 2 accepts, addr_ok=0 until the first
//    data_ok cycle has passed, outstanding peaks at 2, 4 cycles between data_ok pulses.
//  5 ADDR_GAP=2: continuous reads -> addr_ok high 1 of every 3 cycles; responses in issue order.
//  6 Mid-flight reset: 2 outstanding, resetn pulse low -> data_ok never asserts for them,
//    outstanding=0, array keeps prior writes.

Source files
------------

// File: rtl/data_sram_like_responder_if.sv
// Data-side SRAM-like bus between the pipeline's load/store issue logic (master)
// and the data memory (slave).
interface data_sram_like_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_like_responder.sv
// Data memory model: accepts requests into an in-order queue, commits writes at
// acceptance and answers each request with data_ok after a programmable latency.
module data_sram_like_responder #(
    parameter int MEM_AW   = 10,
    parameter int Q_DEPTH  = 2,
    parameter int ADDR_GAP = 0,
    parameter int RESP_LAT = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    data_sram_like_responder_if.slave   bus,
    output logic [$clog2(Q_DEPTH):0]    outstanding
);

    localparam int CNT_W = $clog2(Q_DEPTH) + 1;
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int GAP_W = (ADDR_GAP > 0) ? $clog2(ADDR_GAP + 1) : 1;
    localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    logic [31:0]       mem_q [2**MEM_AW];
    logic [31:0]       qData_q [Q_DEPTH];
    logic [PTR_W-1:0]  headPtr_q, headPtr_d;
    logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
    logic [LAT_W-1:0]  latCnt_q, latCnt_d;

    logic [MEM_AW-1:0] wordIdx;
    logic [31:0]       pushData;
    logic              qEmpty;
    logic              qFull;
    logic              addrOk;
    logic              dataOk;
    logic              accept;
    logic              loadLat;
    logic              unusedBits;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Upper address bits alias and size is left to the master to interpret.
    assign unusedBits = ^{bus.data_sram_size, bus.data_sram_addr[31:MEM_AW+2],
                          bus.data_sram_addr[1:0]};

    assign wordIdx  = bus.data_sram_addr[MEM_AW+1:2];
    assign qEmpty   = (count_q == '0);
    assign qFull    = (count_q == CNT_W'(Q_DEPTH));
    assign addrOk   = resetn & ~qFull & (gapCnt_q == '0);
    assign accept   = bus.data_sram_req & addrOk;
    assign dataOk   = ~qEmpty & (latCnt_q == '0);
    assign pushData = bus.data_sram_wr ? 32'h0 : mem_q[wordIdx];

    assign bus.data_sram_addr_ok = addrOk;
    assign bus.data_sram_data_ok = dataOk;
    assign bus.data_sram_rdata   = dataOk ? qData_q[headPtr_q] : 32'h0;
    assign outstanding           = count_q;

    // The latency counter restarts whenever a different entry reaches the head.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        gapCnt_d  = gapCnt_q;
        latCnt_d  = latCnt_q;
        loadLat   = (accept & qEmpty) | (dataOk & ((count_q > CNT_W'(1)) | accept));

        if (accept) begin
            tailPtr_d = nextPtr(tailPtr_q);
        end
        if (dataOk) begin
            headPtr_d = nextPtr(headPtr_q);
        end

        if (accept && !dataOk) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && dataOk) begin
            count_d = count_q - CNT_W'(1);
        end

        if (accept) begin
            gapCnt_d = GAP_W'(ADDR_GAP);
        end else if (gapCnt_q != '0) begin
            gapCnt_d = gapCnt_q - GAP_W'(1);
        end

        if (loadLat) begin
            latCnt_d = LAT_W'(RESP_LAT - 1);
        end else if (latCnt_q != '0) begin
            latCnt_d = latCnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            gapCnt_q  <= '0;
            latCnt_q  <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            gapCnt_q  <= gapCnt_d;
            latCnt_q  <= latCnt_d;
        end
    end

    // Storage is deliberately not reset so memory survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            qData_q[tailPtr_q] <= pushData;
        end
        if (accept && bus.data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wstrb[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Drives three responder instances (plain, long latency, address gap) from one
// directed stimulus and checks them against a cycle-scheduled transaction model.
`timescale 1ns/1ps
module tb_data_sram_like_responder;

    localparam int NI = 3;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  reqS = 3'b000;
    logic        wrS = 1'b0;
    logic [1:0]  sizeS = 2'd2;
    logic [3:0]  wstrbS = 4'h0;
    logic [31:0] addrS = 32'h0;
    logic [31:0] wdataS = 32'h0;
    logic [2:0]  addrOkS;
    logic [2:0]  dataOkS;
    logic [31:0] rdataS [NI];
    logic [1:0]  outsS [NI];

    int testsRun = 0;
    int testsFailed = 0;

    data_sram_like_responder_if busA ();
    data_sram_like_responder_if busB ();
    data_sram_like_responder_if busC ();

    assign busA.data_sram_req = reqS[0];
    assign busB.data_sram_req = reqS[1];
    assign busC.data_sram_req = reqS[2];
    assign busA.data_sram_wr = wrS;
    assign busB.data_sram_wr = wrS;
    assign busC.data_sram_wr = wrS;
    assign busA.data_sram_size = sizeS;
    assign busB.data_sram_size = sizeS;
    assign busC.data_sram_size = sizeS;
    assign busA.data_sram_wstrb = wstrbS;
    assign busB.data_sram_wstrb = wstrbS;
    assign busC.data_sram_wstrb = wstrbS;
    assign busA.data_sram_addr = addrS;
    assign busB.data_sram_addr = addrS;
    assign busC.data_sram_addr = addrS;
    assign busA.data_sram_wdata = wdataS;
    assign busB.data_sram_wdata = wdataS;
    assign busC.data_sram_wdata = wdataS;
    assign addrOkS = {busC.data_sram_addr_ok, busB.data_sram_addr_ok, busA.data_sram_addr_ok};
    assign dataOkS = {busC.data_sram_data_ok, busB.data_sram_data_ok, busA.data_sram_data_ok};
    assign rdataS[0] = busA.data_sram_rdata;
    assign rdataS[1] = busB.data_sram_rdata;
    assign rdataS[2] = busC.data_sram_rdata;

    data_sram_like_responder #(.MEM_AW(10), .Q_DEPTH(QD), .ADDR_GAP(0), .RESP_LAT(1)) dutA (
        .clk(clk), .resetn(resetn), .bus(busA), .outstanding(outsS[0]));
    data_sram_like_responder #(.MEM_AW(10), .Q_DEPTH(QD), .ADDR_GAP(0), .RESP_LAT(4)) dutB (
        .clk(clk), .resetn(resetn), .bus(busB), .outstanding(outsS[1]));
    data_sram_like_responder #(.MEM_AW(10), .Q_DEPTH(QD), .ADDR_GAP(2), .RESP_LAT(1)) dutC (
        .clk(clk), .resetn(resetn), .bus(busC), .outstanding(outsS[2]));

    always #5 clk = ~clk;

    function automatic int latOf(input int i);
        return (i == 1) ? 4 : 1;
    endfunction

    function automatic int gapOf(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Transaction model: each accepted request is given the cycle its answer is due.
    logic [31:0] mMem [NI][1024];
    logic [3:0]  mKnown [NI][1024];
    logic [31:0] mQData [NI][4];
    bit          mQKnown [NI][4];
    longint      mQResp [NI][4];
    int          mHead [NI];
    int          mCnt [NI];
    longint      mLastAcc [NI];
    longint      mLastResp [NI];
    longint      cyc = 0;

    initial begin : compareProc
        logic        expAddrOk;
        logic        expDataOk;
        logic [31:0] expRdata;
        bit          expKnown;
        int          slot;
        logic [9:0]  idx;
        longint      due;
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 1024; w++) mKnown[i][w] = 4'h0;
            mHead[i] = 0;
            mCnt[i] = 0;
            mLastAcc[i] = -1000;
            mLastResp[i] = -1000;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (!resetn) begin
                    mHead[i] = 0;
                    mCnt[i] = 0;
                    mLastAcc[i] = -1000;
                    mLastResp[i] = -1000;
                end
                expAddrOk = resetn && (mCnt[i] < QD) && (cyc - mLastAcc[i] > gapOf(i));
                expDataOk = (mCnt[i] > 0) && (mQResp[i][mHead[i]] == cyc);
                expRdata  = expDataOk ? mQData[i][mHead[i]] : 32'h0;
                expKnown  = !expDataOk || mQKnown[i][mHead[i]];
                checkOutput($sformatf("addr_ok[%0d]@%0d", i, cyc), 32'(addrOkS[i]), 32'(expAddrOk));
                checkOutput($sformatf("data_ok[%0d]@%0d", i, cyc), 32'(dataOkS[i]), 32'(expDataOk));
                checkOutput($sformatf("outstanding[%0d]@%0d", i, cyc), 32'(outsS[i]), 32'(mCnt[i]));
                if (expKnown) begin
                    checkOutput($sformatf("rdata[%0d]@%0d", i, cyc), rdataS[i], expRdata);
                end
                if (expDataOk) begin
                    mHead[i] = (mHead[i] + 1) % 4;
                    mCnt[i]--;
                end
                if (reqS[i] && expAddrOk) begin
                    idx  = addrS[11:2];
                    slot = (mHead[i] + mCnt[i]) % 4;
                    if (wrS) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrbS[b]) begin
                                mMem[i][idx][8*b +: 8] = wdataS[8*b +: 8];
                                mKnown[i][idx][b] = 1'b1;
                            end
                        end
                        mQData[i][slot] = 32'h0;
                        mQKnown[i][slot] = 1'b1;
                    end else begin
                        mQData[i][slot] = mMem[i][idx];
                        mQKnown[i][slot] = (mKnown[i][idx] == 4'hF);
                    end
                    due = cyc + latOf(i);
                    if (mLastResp[i] + latOf(i) > due) due = mLastResp[i] + latOf(i);
                    mQResp[i][slot] = due;
                    mLastResp[i] = due;
                    mLastAcc[i] = cyc;
                    mCnt[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] wstrb, input logic [31:0] wdata);
        tick();
        reqS   = mask;
        wrS    = wr;
        addrS  = addr;
        wstrbS = wstrb;
        wdataS = wdata;
        sizeS  = 2'd2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            reqS = 3'b000;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimProc
        logic [13:0] aPat;
        logic [13:0] dPat;
        logic [8:0]  cPat;
        logic [8:0]  cDat;
        int          peak;
        int          okCount;

        // Reset held with requests pending on every instance.
        reqS = 3'b111;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset addr_ok", 32'(addrOkS), 32'h0);
        checkOutput("reset data_ok", 32'(dataOkS), 32'h0);
        checkOutput("reset rdata A", rdataS[0], 32'h0);
        tick();
        resetn = 1'b1;
        reqS = 3'b000;
        @(negedge clk);
        checkOutput("release addr_ok", 32'(addrOkS), 32'h7);

        // Full-word write then read on A.
        applyStimulus(3'b001, 1'b1, 32'h10, 4'hF, 32'hA5A5_1234);
        @(negedge clk);
        checkOutput("t2 write addr_ok", 32'(addrOkS[0]), 32'h1);
        applyStimulus(3'b001, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2 write data_ok", 32'(dataOkS[0]), 32'h1);
        checkOutput("t2 write rdata", rdataS[0], 32'h0);
        idle(1);
        @(negedge clk);
        checkOutput("t2 read data_ok", 32'(dataOkS[0]), 32'h1);
        checkOutput("t2 read rdata", rdataS[0], 32'hA5A5_1234);
        idle(1);
        @(negedge clk);
        checkOutput("t2 idle data_ok", 32'(dataOkS[0]), 32'h0);

        // Byte-lane write, then an all-lanes-off write.
        applyStimulus(3'b001, 1'b1, 32'h13, 4'h8, 32'h7700_0000);
        applyStimulus(3'b001, 1'b0, 32'h10, 4'h0, 32'h0);
        applyStimulus(3'b001, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("t3 byte merge rdata", rdataS[0], 32'h77A5_1234);
        applyStimulus(3'b001, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t3 strobe0 data_ok", 32'(dataOkS[0]), 32'h1);
        idle(1);
        @(negedge clk);
        checkOutput("t3 strobe0 unchanged", rdataS[0], 32'h77A5_1234);
        idle(2);

        // Queue-full behaviour on B with requests held high.
        applyStimulus(3'b010, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF);
        idle(6);
        peak = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(3'b010, 1'b0, 32'h20, 4'h0, 32'h0);
            @(negedge clk);
            aPat[k] = addrOkS[1];
            dPat[k] = dataOkS[1];
            if (int'(outsS[1]) > peak) peak = int'(outsS[1]);
        end
        idle(10);
        checkOutput("t4 addr_ok pattern", 32'(aPat), 32'h2223);
        checkOutput("t4 data_ok pattern", 32'(dPat), 32'h1110);
        checkOutput("t4 outstanding peak", 32'(peak), 32'h2);

        // Address gap on C with continuous reads.
        applyStimulus(3'b100, 1'b1, 32'h30, 4'hF, 32'h1234_5678);
        idle(3);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(3'b100, 1'b0, 32'h30, 4'h0, 32'h0);
            @(negedge clk);
            cPat[k] = addrOkS[2];
            cDat[k] = dataOkS[2];
        end
        idle(3);
        checkOutput("t5 addr_ok pattern", 32'(cPat), 32'h049);
        checkOutput("t5 data_ok pattern", 32'(cDat), 32'h092);

        // Reset while B has requests in flight.
        applyStimulus(3'b010, 1'b0, 32'h20, 4'h0, 32'h0);
        applyStimulus(3'b010, 1'b0, 32'h20, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t6 outstanding before", 32'(outsS[1]), 32'h1);
        tick();
        resetn = 1'b0;
        reqS = 3'b000;
        @(negedge clk);
        checkOutput("t6 outstanding in reset", 32'(outsS[1]), 32'h0);
        tick();
        resetn = 1'b1;
        okCount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            okCount += int'(dataOkS[1]);
            tick();
        end
        checkOutput("t6 dropped data_ok", 32'(okCount), 32'h0);
        checkOutput("t6 outstanding after", 32'(outsS[1]), 32'h0);
        applyStimulus(3'b010, 1'b0, 32'h20, 4'h0, 32'h0);
        idle(4);
        @(negedge clk);
        checkOutput("t6 retained data_ok B", 32'(dataOkS[1]), 32'h1);
        checkOutput("t6 retained rdata B", rdataS[1], 32'hDEAD_BEEF);
        applyStimulus(3'b001, 1'b0, 32'h10, 4'h0, 32'h0);
        idle(1);
        @(negedge clk);
        checkOutput("t6 retained rdata A", rdataS[0], 32'h77A5_1234);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
